// File: rtl/seq_pkg.sv
// Shared sequence definitions: FSM state encoding and the default sync pattern,
// used by the sync-word transmitter and by the matching 10110 detector.
package seq_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SYNC = 2'd1,
      ST_DATA = 2'd2,
      ST_GAP  = 2'd3
   } state_t;

   localparam int                  SYNC_LEN      = 5;
   localparam logic [SYNC_LEN-1:0] SYNC_WORD_DEF = 5'b10110;

   // Sync bits go out MSB first, so bit index 0 on the line is word[SYNC_LEN-1].
   function automatic logic sync_bit(input logic [SYNC_LEN-1:0] word,
                                     input logic [2:0]          idx);
      return word[3'(SYNC_LEN - 1) - idx];
   endfunction

endpackage

// File: rtl/piso_shift.sv
// Parallel-in serial-out shift register: parallel load, shift-left enable,
// MSB presented on the serial output.
module piso_shift #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             i_clr,
   input  logic             i_load,
   input  logic             i_shift,
   input  logic [WIDTH-1:0] i_data,
   output logic             o_msb
);

   logic [WIDTH-1:0] r_sreg;

   always_ff @(posedge clk) begin
      if (i_clr) begin
         r_sreg <= '0;
      end else if (i_load) begin
         r_sreg <= i_data;
      end else if (i_shift) begin
         r_sreg <= r_sreg << 1;
      end
   end

   assign o_msb = r_sreg[WIDTH-1];

endmodule

// File: rtl/sync_frame_tx.sv
// Serial frame transmitter: each accepted payload goes out as SYNC_WORD then
// the payload MSB first, followed by GAP_CYCLES forced-idle line cycles.
module sync_frame_tx
   import seq_pkg::*;
#(
   parameter logic [SYNC_LEN-1:0] SYNC_WORD  = SYNC_WORD_DEF,
   parameter int                  DATA_W     = 8,
   parameter int                  GAP_CYCLES = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              in_ready,
   output logic              out_data,
   output logic              out_valid,
   output logic              busy,
   output logic              frame_done
);

   localparam int               CNT_W     = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(DATA_W - 1);
   localparam logic [3:0]       LAST_GAP  = 4'(GAP_CYCLES - 1);
   localparam logic [2:0]       LAST_SYNC = 3'(SYNC_LEN - 1);

   state_t           r_state, w_nxt_state;
   logic [2:0]       r_sync_cnt, w_nxt_sync_cnt;
   logic [CNT_W-1:0] r_data_cnt, w_nxt_data_cnt;
   logic [3:0]       r_gap_cnt, w_nxt_gap_cnt;
   logic             r_out_data, r_out_valid, r_frame_done;
   logic             w_nxt_out_data, w_nxt_out_valid, w_nxt_frame_done;
   logic             w_accept, w_shift_en, w_shift_msb;

   assign in_ready   = (r_state == ST_IDLE) && !rst;
   assign w_accept   = in_valid && in_ready;
   assign busy       = (r_state != ST_IDLE);
   assign out_data   = r_out_data;
   assign out_valid  = r_out_valid;
   assign frame_done = r_frame_done;

   // Shifting on every edge that enters a DATA cycle keeps the bit to be
   // registered for that cycle sitting on the MSB tap.
   assign w_shift_en = (w_nxt_state == ST_DATA);

   piso_shift #(.WIDTH(DATA_W)) u_piso (
      .clk     (clk),
      .i_clr   (rst),
      .i_load  (w_accept),
      .i_shift (w_shift_en),
      .i_data  (in_data),
      .o_msb   (w_shift_msb)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= ST_IDLE;
         r_sync_cnt   <= '0;
         r_data_cnt   <= '0;
         r_gap_cnt    <= '0;
         r_out_data   <= 1'b0;
         r_out_valid  <= 1'b0;
         r_frame_done <= 1'b0;
      end else begin
         r_state      <= w_nxt_state;
         r_sync_cnt   <= w_nxt_sync_cnt;
         r_data_cnt   <= w_nxt_data_cnt;
         r_gap_cnt    <= w_nxt_gap_cnt;
         r_out_data   <= w_nxt_out_data;
         r_out_valid  <= w_nxt_out_valid;
         r_frame_done <= w_nxt_frame_done;
      end
   end

   always_comb begin
      w_nxt_state    = r_state;
      w_nxt_sync_cnt = r_sync_cnt;
      w_nxt_data_cnt = r_data_cnt;
      w_nxt_gap_cnt  = r_gap_cnt;
      case (r_state)
         ST_IDLE: begin
            if (w_accept) begin
               w_nxt_state    = ST_SYNC;
               w_nxt_sync_cnt = '0;
            end
         end
         ST_SYNC: begin
            if (r_sync_cnt == LAST_SYNC) begin
               w_nxt_state    = ST_DATA;
               w_nxt_data_cnt = '0;
            end else begin
               w_nxt_sync_cnt = r_sync_cnt + 3'd1;
            end
         end
         ST_DATA: begin
            if (r_data_cnt == LAST_BIT) begin
               if (GAP_CYCLES == 0) begin
                  w_nxt_state = ST_IDLE;
               end else begin
                  w_nxt_state   = ST_GAP;
                  w_nxt_gap_cnt = '0;
               end
            end else begin
               w_nxt_data_cnt = r_data_cnt + 1'b1;
            end
         end
         ST_GAP: begin
            if (r_gap_cnt == LAST_GAP) begin
               w_nxt_state = ST_IDLE;
            end else begin
               w_nxt_gap_cnt = r_gap_cnt + 4'd1;
            end
         end
         default: w_nxt_state = ST_IDLE;
      endcase
   end

   // Line outputs are decoded from the upcoming state so they can be registered
   // and still line up with the state they belong to.
   always_comb begin
      w_nxt_out_data   = 1'b0;
      w_nxt_out_valid  = 1'b0;
      w_nxt_frame_done = 1'b0;
      case (w_nxt_state)
         ST_SYNC: begin
            w_nxt_out_valid = 1'b1;
            w_nxt_out_data  = sync_bit(SYNC_WORD, w_nxt_sync_cnt);
         end
         ST_DATA: begin
            w_nxt_out_valid  = 1'b1;
            w_nxt_out_data   = w_shift_msb;
            w_nxt_frame_done = (w_nxt_data_cnt == LAST_BIT);
         end
         default: begin
            w_nxt_out_valid = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_sync_frame_tx.sv
// Bench for sync_frame_tx: a GAP_CYCLES=2 and a GAP_CYCLES=0 build share one
// stimulus stream and are compared cycle by cycle against a frame-offset model.
module tb_sync_frame_tx;

   localparam int         DW   = 8;
   localparam logic [4:0] SW   = 5'b10110;
   localparam int         FLEN = 5 + DW;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic [DW-1:0] in_data;
   logic [1:0]    rdy, od, ov, bsy, fd;

   int            n_checks = 0;
   int            n_errors = 0;
   int            e = 0;
   int            acc  [2];
   logic [DW-1:0] pl   [2];
   bit            bsy_m [2];
   int            dcur [2];
   int            gapc [2];
   int            run  [2];
   bit            seen [2];
   bit            b2b_on;
   logic [4:0]    hist;
   bit            det_on;
   int            det_cnt;

   always #5 clk = ~clk;

   sync_frame_tx #(.SYNC_WORD(SW), .DATA_W(DW), .GAP_CYCLES(2)) u_dut0 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
      .in_ready(rdy[0]), .out_data(od[0]), .out_valid(ov[0]),
      .busy(bsy[0]), .frame_done(fd[0])
   );

   sync_frame_tx #(.SYNC_WORD(SW), .DATA_W(DW), .GAP_CYCLES(0)) u_dut1 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
      .in_ready(rdy[1]), .out_data(od[1]), .out_valid(ov[1]),
      .busy(bsy[1]), .frame_done(fd[1])
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
      end
   endtask

   // One clock: apply accept/reset rules at the edge, then compare the line.
   task automatic step();
      int   d;
      logic ev, ed, efd, eb;
      @(posedge clk);
      e++;
      for (int i = 0; i < 2; i++) begin
         if (rst) begin
            acc[i] = -1;
         end else if (!bsy_m[i] && in_valid) begin
            acc[i] = e;
            pl[i]  = in_data;
         end
      end
      #1;
      for (int i = 0; i < 2; i++) begin
         d   = (acc[i] >= 0) ? (e - acc[i] + 1) : 0;
         ev  = (d >= 1) && (d <= FLEN);
         ed  = 1'b0;
         if (ev && d <= 5)  ed = SW[5 - d];
         else if (ev)       ed = pl[i][DW - 1 - (d - 6)];
         efd = (d == FLEN);
         eb  = (d >= 1) && (d <= FLEN + gapc[i]);
         chk($sformatf("out_valid%0d", i),  32'(ov[i]),  32'(ev));
         chk($sformatf("out_data%0d", i),   32'(od[i]),  32'(ed));
         chk($sformatf("frame_done%0d", i), 32'(fd[i]),  32'(efd));
         chk($sformatf("busy%0d", i),       32'(bsy[i]), 32'(eb));
         bsy_m[i] = eb;
         if (!eb) acc[i] = -1;
         dcur[i] = eb ? d : 0;
         if (!ov[i]) begin
            run[i]++;
         end else begin
            if (b2b_on && seen[i] && run[i] > 0)
               chk($sformatf("gap_len%0d", i), run[i], gapc[i] + 1);
            run[i]  = 0;
            seen[i] = 1'b1;
         end
      end
      hist = {hist[3:0], od[0]};
      if (det_on && hist == SW) begin
         det_cnt++;
         chk("det_latency", dcur[0], 5);
      end
   endtask

   task automatic drive(input logic r, input logic v, input logic [DW-1:0] dt);
      rst      = r;
      in_valid = v;
      in_data  = dt;
      #1;
      for (int i = 0; i < 2; i++)
         chk($sformatf("in_ready%0d", i), 32'(rdy[i]), 32'(!bsy_m[i] && !r));
   endtask

   initial begin
      int  nb;
      int  na;
      bit  rdone;
      logic r;
      rst      = 1'b1;
      in_valid = 1'b0;
      in_data  = '0;
      acc      = '{-1, -1};
      bsy_m    = '{1'b0, 1'b0};
      dcur     = '{0, 0};
      gapc     = '{2, 0};
      run      = '{0, 0};
      seen     = '{1'b0, 1'b0};
      b2b_on   = 1'b0;
      det_on   = 1'b0;
      det_cnt  = 0;
      hist     = '0;

      for (int c = 0; c < 3; c++) begin step(); drive(1'b1, 1'b0, '0); end
      step(); drive(1'b0, 1'b0, '0);

      // Single frame 0xA5 with the data bus churning after the accept.
      step(); drive(1'b0, 1'b1, 8'hA5);
      for (int c = 0; c < 20; c++) begin step(); drive(1'b0, 1'b0, 8'($urandom)); end

      // Back-to-back 0x3C then 0xC3 with in_valid held high.
      b2b_on = 1'b1;
      seen   = '{1'b0, 1'b0};
      nb     = 0;
      step(); drive(1'b0, 1'b1, 8'h3C);
      for (int c = 0; c < 45; c++) begin
         step();
         if (acc[0] == e) nb++;
         drive(1'b0, nb < 2, (nb == 0) ? 8'h3C : 8'hC3);
      end
      b2b_on = 1'b0;

      // Reset in the eighth line cycle of a frame.
      rdone = 1'b0;
      step(); drive(1'b0, 1'b1, 8'h5A);
      for (int c = 0; c < 30; c++) begin
         step();
         r = (dcur[0] == 8) && !rdone;
         if (r) rdone = 1'b1;
         drive(r, 1'b0, 8'($urandom));
      end
      chk("mid_reset_hit", 32'(rdone), 32'(1'b1));

      // Random traffic with occasional resets.
      for (int c = 0; c < 1500; c++) begin
         step();
         drive($urandom_range(0, 99) < 2, $urandom_range(0, 9) < 7, 8'($urandom));
      end

      // Loopback into an overlapping 10110 detector, 100 all-zero payloads.
      for (int c = 0; c < 2; c++) begin step(); drive(1'b1, 1'b0, '0); end
      hist    = '0;
      det_on  = 1'b1;
      det_cnt = 0;
      na      = 0;
      step(); drive(1'b0, 1'b1, '0);
      for (int c = 0; c < 2000; c++) begin
         step();
         if (acc[0] == e) na++;
         drive(1'b0, na < 100, '0);
      end
      det_on = 1'b0;
      chk("det_frames", na, 100);
      chk("det_count", det_cnt, 100);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
